// File: rtl/active_list_rob_if.sv
// Bundle of dispatch, writeback, branch-resolve, retire and occupancy signals of the active list.
// The slave modport belongs to the active list. The master modport belongs to the rename/commit side.
interface active_list_rob_if #(
  parameter int DEPTH      = 16,
  parameter int RETIRE_W   = 2,
  parameter int PHYS_IDX_W = 6,
  parameter int ADDR_W     = 32
);
  localparam int IDX_W = $clog2(DEPTH);

  // Dispatch: a slot is allocated on any edge where disp_valid && disp_ready.
  // disp_ready must not depend on disp_valid.
  logic                             disp_valid;
  logic                             disp_ready;
  logic [ADDR_W-1:0]                disp_pc;
  logic                             disp_uses_rw;
  logic [PHYS_IDX_W-1:0]            disp_reclaim_phys;
  logic                             disp_is_store;
  logic [IDX_W-1:0]                 disp_id;
  logic                             disp_color;
  logic                             wb_valid;
  logic [IDX_W-1:0]                 wb_id;
  logic                             br_valid;
  logic                             br_mispredict;
  logic [IDX_W-1:0]                 br_id;
  logic                             br_color;
  logic [RETIRE_W-1:0]              ret_valid;
  logic [RETIRE_W*ADDR_W-1:0]       ret_pc;
  logic [RETIRE_W-1:0]              ret_uses_rw;
  logic [RETIRE_W*PHYS_IDX_W-1:0]   ret_reclaim_phys;
  logic                             ret_is_store;
  logic                             squash_valid;
  logic [IDX_W:0]                   squash_count;
  logic [IDX_W:0]                   count;
  logic                             empty;
  logic                             full;

  modport master (
    output disp_valid, disp_pc, disp_uses_rw, disp_reclaim_phys, disp_is_store,
    output wb_valid, wb_id, br_valid, br_mispredict, br_id, br_color,
    input  disp_ready, disp_id, disp_color, ret_valid, ret_pc, ret_uses_rw,
    input  ret_reclaim_phys, ret_is_store, squash_valid, squash_count, count, empty, full
  );

  modport slave (
    input  disp_valid, disp_pc, disp_uses_rw, disp_reclaim_phys, disp_is_store,
    input  wb_valid, wb_id, br_valid, br_mispredict, br_id, br_color,
    output disp_ready, disp_id, disp_color, ret_valid, ret_pc, ret_uses_rw,
    output ret_reclaim_phys, ret_is_store, squash_valid, squash_count, count, empty, full
  );
endinterface

// File: rtl/active_list_rob.sv
// Active list / reorder buffer: circular buffer with colored head/tail pointers, in-order multi-retire
// and truncation of younger entries on branch mispredict.
module active_list_rob #(
  parameter int DEPTH      = 16,
  parameter int RETIRE_W   = 2,
  parameter int PHYS_IDX_W = 6,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  active_list_rob_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]       head, tail, cnt;
  logic [PTR_W-1:0]       br_ptr, br_off, br_next;
  logic [IDX_W-1:0]       wb_off;
  logic                   flush_now, accept, wb_live, wb_squashed;
  logic [DEPTH-1:0]       done;
  logic [DEPTH-1:0]       squash_mask;
  logic [ADDR_W-1:0]      pc_mem      [DEPTH];
  logic [PHYS_IDX_W-1:0]  reclaim_mem [DEPTH];
  logic [DEPTH-1:0]       uses_rw_mem;
  logic [DEPTH-1:0]       store_mem;

  logic [IDX_W-1:0]       scan_idx [RETIRE_W];
  logic [RETIRE_W-1:0]    grp;
  logic [PTR_W-1:0]       grp_n;

  logic [RETIRE_W-1:0]            ret_valid_q, ret_uses_rw_q;
  logic [RETIRE_W*ADDR_W-1:0]     ret_pc_q;
  logic [RETIRE_W*PHYS_IDX_W-1:0] ret_reclaim_q;
  logic                           ret_is_store_q, squash_valid_q;
  logic [PTR_W-1:0]               squash_count_q;

  assign cnt         = tail - head;
  assign br_ptr      = {bus.br_color, bus.br_id};
  assign br_off      = br_ptr - head;
  assign br_next     = br_ptr + PTR_W'(1);
  assign flush_now   = bus.br_valid && bus.br_mispredict && (br_off < cnt);
  assign accept      = bus.disp_valid && bus.disp_ready;
  assign wb_off      = bus.wb_id - head[IDX_W-1:0];
  assign wb_live     = {1'b0, wb_off} < cnt;
  assign wb_squashed = flush_now && ({1'b0, wb_off} > br_off);

  assign bus.disp_ready = (cnt != PTR_W'(DEPTH)) && !flush_now;
  assign bus.disp_id    = tail[IDX_W-1:0];
  assign bus.disp_color = tail[IDX_W];
  assign bus.count      = cnt;
  assign bus.empty      = (cnt == '0);
  assign bus.full       = (cnt == PTR_W'(DEPTH));
  assign bus.ret_valid        = ret_valid_q;
  assign bus.ret_pc           = ret_pc_q;
  assign bus.ret_uses_rw      = ret_uses_rw_q;
  assign bus.ret_reclaim_phys = ret_reclaim_q;
  assign bus.ret_is_store     = ret_is_store_q;
  assign bus.squash_valid     = squash_valid_q;
  assign bus.squash_count     = squash_count_q;

  // Entries younger than the mispredicted branch that are still live.
  always_comb begin
    squash_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      squash_mask[i] = flush_now && ({1'b0, IDX_W'(i) - head[IDX_W-1:0]} > br_off) &&
                       ({1'b0, IDX_W'(i) - head[IDX_W-1:0]} < cnt);
    end
  end

  // Longest done prefix from head; stops at a not-done entry, a non-leading store,
  // or past the branch being flushed this cycle.
  always_comb begin
    logic stop;
    stop  = 1'b0;
    grp   = '0;
    grp_n = '0;
    for (int k = 0; k < RETIRE_W; k++) begin
      scan_idx[k] = head[IDX_W-1:0] + IDX_W'(k);
      if (!stop) begin
        if ((PTR_W'(k) >= cnt) || !done[scan_idx[k]] || ((k > 0) && store_mem[scan_idx[k]]) ||
            (flush_now && (PTR_W'(k) > br_off))) begin
          stop = 1'b1;
        end else begin
          grp[k] = 1'b1;
          grp_n  = grp_n + PTR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pc_mem[tail[IDX_W-1:0]]      <= bus.disp_pc;
      reclaim_mem[tail[IDX_W-1:0]] <= bus.disp_reclaim_phys;
      uses_rw_mem[tail[IDX_W-1:0]] <= bus.disp_uses_rw;
      store_mem[tail[IDX_W-1:0]]   <= bus.disp_is_store;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head           <= '0;
      tail           <= '0;
      done           <= '0;
      ret_valid_q    <= '0;
      ret_pc_q       <= '0;
      ret_uses_rw_q  <= '0;
      ret_reclaim_q  <= '0;
      ret_is_store_q <= 1'b0;
      squash_valid_q <= 1'b0;
      squash_count_q <= '0;
    end else begin
      head           <= head + grp_n;
      squash_valid_q <= flush_now;
      squash_count_q <= flush_now ? (tail - br_next) : '0;
      ret_is_store_q <= grp[0] && store_mem[scan_idx[0]];
      for (int k = 0; k < RETIRE_W; k++) begin
        ret_valid_q[k]   <= grp[k];
        ret_uses_rw_q[k] <= grp[k] && uses_rw_mem[scan_idx[k]];
        ret_pc_q[k*ADDR_W +: ADDR_W] <= grp[k] ? pc_mem[scan_idx[k]] : '0;
        ret_reclaim_q[k*PHYS_IDX_W +: PHYS_IDX_W] <= grp[k] ? reclaim_mem[scan_idx[k]] : '0;
        if (grp[k]) done[scan_idx[k]] <= 1'b0;
      end
      if (flush_now) begin
        tail <= br_next;
        for (int i = 0; i < DEPTH; i++) begin
          if (squash_mask[i]) done[i] <= 1'b0;
        end
      end else if (accept) begin
        tail <= tail + PTR_W'(1);
        done[tail[IDX_W-1:0]] <= 1'b0;
      end
      if (bus.wb_valid && wb_live && !wb_squashed) done[bus.wb_id] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_active_list_rob.sv
// Directed bench for active_list_rob: allocation/wrap, multi-retire, store rule, mispredict truncation, reset.
module tb_active_list_rob;
  localparam int DEPTH = 16, RETIRE_W = 2, PHYS_IDX_W = 6, ADDR_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  active_list_rob_if #(.DEPTH(DEPTH), .RETIRE_W(RETIRE_W), .PHYS_IDX_W(PHYS_IDX_W), .ADDR_W(ADDR_W)) bus ();

  active_list_rob #(.DEPTH(DEPTH), .RETIRE_W(RETIRE_W), .PHYS_IDX_W(PHYS_IDX_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.disp_valid = 1'b0; bus.disp_pc = '0; bus.disp_uses_rw = 1'b0;
    bus.disp_reclaim_phys = '0; bus.disp_is_store = 1'b0;
    bus.wb_valid = 1'b0; bus.wb_id = '0;
    bus.br_valid = 1'b0; bus.br_mispredict = 1'b0; bus.br_id = '0; bus.br_color = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic dispatch(input logic [31:0] pc, input logic st, input logic [3:0] exp_id, input logic exp_col);
    bus.disp_valid = 1'b1; bus.disp_pc = pc; bus.disp_is_store = st;
    bus.disp_uses_rw = 1'b1; bus.disp_reclaim_phys = PHYS_IDX_W'(exp_id);
    #1;
    n_cmp++;
    if (bus.disp_id !== exp_id || bus.disp_color !== exp_col || bus.disp_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL dispatch: id=%0d color=%0d ready=%0d, required id=%0d color=%0d ready=1",
               bus.disp_id, bus.disp_color, bus.disp_ready, exp_id, exp_col);
    end
    tick();
    bus.disp_valid = 1'b0;
  endtask

  task automatic wb(input logic [3:0] id);
    bus.wb_valid = 1'b1; bus.wb_id = id;
    tick();
    bus.wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.disp_ready !== 1'b1 ||
        bus.disp_color !== 1'b0 || bus.ret_valid !== 2'b00 || bus.squash_valid !== 1'b0 ||
        bus.squash_count !== 5'd0) begin
      n_bad++;
      $display("FAIL reset: count=%0d empty=%0d full=%0d ready=%0d color=%0d ret=%b sq=%0d sqc=%0d, required 0 1 0 1 0 00 0 0",
               bus.count, bus.empty, bus.full, bus.disp_ready, bus.disp_color, bus.ret_valid,
               bus.squash_valid, bus.squash_count);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) dispatch(32'h1000 + 32'(4 * i), 1'b0, 4'(i), 1'b0);
    n_cmp++;
    if (bus.full !== 1'b1 || bus.disp_ready !== 1'b0 || bus.count !== 5'd16) begin
      n_bad++;
      $display("FAIL fill: full=%0d ready=%0d count=%0d, required 1 0 16", bus.full, bus.disp_ready, bus.count);
    end
  endtask

  task automatic test_multi_retire();
    wb(4'd1);
    wb(4'd0);
    tick();
    n_cmp++;
    if (bus.ret_valid !== 2'b11 || bus.ret_pc !== {32'h1004, 32'h1000} || bus.count !== 5'd14) begin
      n_bad++;
      $display("FAIL multi_retire: ret=%b pc=%h count=%0d, required 11 0000100400001000 14",
               bus.ret_valid, bus.ret_pc, bus.count);
    end
    n_cmp++;
    if (bus.ret_uses_rw !== 2'b11 || bus.ret_reclaim_phys !== {6'd1, 6'd0} || bus.ret_is_store !== 1'b0) begin
      n_bad++;
      $display("FAIL retire_reclaim: rw=%b phys=%h st=%0d, required 11 040 0",
               bus.ret_uses_rw, bus.ret_reclaim_phys, bus.ret_is_store);
    end
    tick();
    n_cmp++;
    if (bus.ret_valid !== 2'b00) begin
      n_bad++;
      $display("FAIL retire_idle: ret=%b, required 00", bus.ret_valid);
    end
  endtask

  task automatic test_wrap();
    int budget;
    for (int i = 2; i < DEPTH; i++) wb(4'(i));
    budget = 0;
    while (!bus.empty && budget < 20) begin
      tick();
      budget++;
    end
    n_cmp++;
    if (bus.empty !== 1'b1 || bus.count !== 5'd0) begin
      n_bad++;
      $display("FAIL drain: empty=%0d count=%0d, required 1 0", bus.empty, bus.count);
    end
    for (int i = 0; i < 4; i++) dispatch(32'h3000 + 32'(4 * i), 1'b0, 4'(i), 1'b1);
    n_cmp++;
    if (bus.count !== 5'd4 || bus.full !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap: count=%0d full=%0d, required 4 0", bus.count, bus.full);
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    for (int i = 0; i < 10; i++) dispatch(32'h4000 + 32'(4 * i), 1'b0, 4'(i), 1'b0);
    bus.br_valid = 1'b1; bus.br_mispredict = 1'b1; bus.br_id = 4'd5; bus.br_color = 1'b0;
    tick();
    bus.br_valid = 1'b0; bus.br_mispredict = 1'b0;
    n_cmp++;
    if (bus.squash_valid !== 1'b1 || bus.squash_count !== 5'd4 || bus.count !== 5'd6 || bus.disp_id !== 4'd6) begin
      n_bad++;
      $display("FAIL mispredict: sq=%0d sqc=%0d count=%0d tail=%0d, required 1 4 6 6",
               bus.squash_valid, bus.squash_count, bus.count, bus.disp_id);
    end
    wb(4'd7);
    n_cmp++;
    if (bus.squash_valid !== 1'b0 || bus.count !== 5'd6 || bus.ret_valid !== 2'b00) begin
      n_bad++;
      $display("FAIL squash_pulse: sq=%0d count=%0d ret=%b, required 0 6 00", bus.squash_valid, bus.count, bus.ret_valid);
    end
    bus.br_valid = 1'b1; bus.br_mispredict = 1'b1; bus.br_id = 4'd8; bus.br_color = 1'b0;
    tick();
    bus.br_valid = 1'b0; bus.br_mispredict = 1'b0;
    n_cmp++;
    if (bus.squash_valid !== 1'b0 || bus.count !== 5'd6 || bus.disp_id !== 4'd6) begin
      n_bad++;
      $display("FAIL stale_branch: sq=%0d count=%0d tail=%0d, required 0 6 6", bus.squash_valid, bus.count, bus.disp_id);
    end
  endtask

  task automatic test_store_rule();
    do_reset();
    dispatch(32'h2000, 1'b1, 4'd0, 1'b0);
    dispatch(32'h2004, 1'b1, 4'd1, 1'b0);
    wb(4'd1);
    wb(4'd0);
    tick();
    n_cmp++;
    if (bus.ret_valid !== 2'b01 || bus.ret_is_store !== 1'b1 || bus.ret_pc !== {32'h0, 32'h2000}) begin
      n_bad++;
      $display("FAIL store_first: ret=%b st=%0d pc=%h, required 01 1 0000000000002000", bus.ret_valid, bus.ret_is_store, bus.ret_pc);
    end
    tick();
    n_cmp++;
    if (bus.ret_valid !== 2'b01 || bus.ret_is_store !== 1'b1 || bus.ret_pc !== {32'h0, 32'h2004}) begin
      n_bad++;
      $display("FAIL store_second: ret=%b st=%0d pc=%h, required 01 1 0000000000002004", bus.ret_valid, bus.ret_is_store, bus.ret_pc);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 8; i++) dispatch(32'h5000 + 32'(4 * i), 1'b0, 4'(i), 1'b0);
    bus.disp_valid = 1'b1; bus.disp_pc = 32'h6000;
    bus.br_valid = 1'b1; bus.br_mispredict = 1'b1; bus.br_id = 4'd3; bus.br_color = 1'b0;
    #1;
    n_cmp++;
    if (bus.disp_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_ready: ready=%0d, required 0", bus.disp_ready);
    end
    tick();
    idle_inputs();
    n_cmp++;
    if (bus.count !== 5'd4 || bus.disp_id !== 4'd4 || bus.squash_count !== 5'd4) begin
      n_bad++;
      $display("FAIL flush_dispatch: count=%0d tail=%0d sqc=%0d, required 4 4 4", bus.count, bus.disp_id, bus.squash_count);
    end
    for (int i = 4; i < 8; i++) dispatch(32'h7000 + 32'(4 * i), 1'b0, 4'(i), 1'b0);
    wb(4'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (bus.count !== 5'd0 || bus.ret_valid !== 2'b00 || bus.empty !== 1'b1 || bus.disp_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset: count=%0d ret=%b empty=%0d ready=%0d, required 0 00 1 1",
               bus.count, bus.ret_valid, bus.empty, bus.disp_ready);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fill();
    test_multi_retire();
    test_wrap();
    test_mispredict();
    test_store_rule();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
